// File: rtl/cache_line_ctrl.sv
// Line refill / write-back engine between the data cache and main memory.
// Define CACHE_CWF_EN to enable critical-word-first fill ordering.
module cache_line_ctrl #(
    parameter int WORDS_PER_LINE = 16,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_dirty,
    input  logic [31:0]      req_victim_addr,
    output logic [IDX_W-1:0] vic_idx,
    input  logic [31:0]      vic_data,
    output logic             fill_we,
    output logic [IDX_W-1:0] fill_idx,
    output logic [31:0]      fill_data,
    output logic             done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              OFF_W     = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

    logic [1:0]       state;
    logic [31:0]      line_base;
    logic [31:0]      vic_base;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] start_idx;
    logic [31:0]      wb_off;
    logic [31:0]      fill_off;
    logic             unused_ok;

`ifdef CACHE_CWF_EN
    assign start_idx = req_addr[OFF_W-1:2];
`else
    assign start_idx = '0;
`endif

    assign unused_ok = ^{req_addr[OFF_W-1:0], req_victim_addr[OFF_W-1:0]};

    // In WB/FILL mem_req is always high, so a bare mem_ack completes a beat there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            line_base <= '0;
            vic_base  <= '0;
            idx       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        line_base <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        vic_base  <= {req_victim_addr[31:OFF_W], {OFF_W{1'b0}}};
                        idx       <= start_idx;
                        cnt       <= '0;
                        state     <= req_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        if (cnt == LAST_BEAT) begin
                            cnt   <= '0;
                            state <= S_FILL;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        idx <= idx + ONE;
                        cnt <= cnt + ONE;
                        if (cnt == LAST_BEAT) begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // idx is only IDX_W wide, so the fill address wraps inside the line.
    assign wb_off   = {{(30-IDX_W){1'b0}}, cnt, 2'b00};
    assign fill_off = {{(30-IDX_W){1'b0}}, idx, 2'b00};

    always_comb begin
        req_ready = 1'b0;
        vic_idx   = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = vic_base + wb_off;
                vic_idx   = cnt;
                mem_wdata = vic_data;
            end
            S_FILL: begin
                mem_req   = 1'b1;
                mem_addr  = line_base + fill_off;
                fill_we   = mem_ack;
                fill_idx  = idx;
                fill_data = mem_rdata;
            end
            default: done = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl: table of miss scenarios plus a mid-fill reset sequence.
module tb_cache_line_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_dirty;
    logic [31:0] req_victim_addr;
    logic [3:0]  vic_idx;
    logic [31:0] vic_data;
    logic        fill_we;
    logic [3:0]  fill_idx;
    logic [31:0] fill_data;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        dirty;
        logic [31:0] victim;
        int          period;
        int          pulseCyc;
        int          expDone;
    } vec_t;

    vec_t vecs[5];

    cache_line_ctrl #(.WORDS_PER_LINE(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_dirty(req_dirty), .req_victim_addr(req_victim_addr),
        .vic_idx(vic_idx), .vic_data(vic_data),
        .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Cache victim words and memory read data are fixed patterns the bench can predict.
    assign vic_data  = 32'hBEEF_0000 | {28'd0, vic_idx};
    assign mem_rdata = mem_addr ^ 32'hC0DE_0000;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int firstIdx(input logic [31:0] addr);
`ifdef CACHE_CWF_EN
        return int'(addr[5:2]);
`else
        return 0;
`endif
    endfunction

    task automatic applyStimulus(input vec_t v);
        int nWb, nb, beat, waitCnt, fills, doneCyc, f, i;
        logic [31:0] lineBase, vicBase, expAddr;
        nWb      = v.dirty ? 16 : 0;
        nb       = nWb + 16;
        lineBase = {v.addr[31:6], 6'b0};
        vicBase  = {v.victim[31:6], 6'b0};
        @(negedge clk);
        req_valid       = 1'b1;
        req_addr        = v.addr;
        req_dirty       = v.dirty;
        req_victim_addr = v.victim;
        mem_ack         = 1'b0;
        #1 checkOutput("req_ready idle", req_ready, 1);
        @(posedge clk);
        beat = 0; waitCnt = 0; fills = 0; doneCyc = -1;
        for (int cyc = 1; cyc <= 400 && doneCyc < 0; cyc++) begin
            @(negedge clk);
            req_valid = (cyc == v.pulseCyc);
            if (cyc == v.pulseCyc) begin
                req_addr  = 32'h0000_7770;
                req_dirty = 1'b0;
            end
            mem_ack = (waitCnt == v.period - 1);
            #1;
            if (done) begin
                doneCyc = cyc;
                checkOutput("mem_req in done", mem_req, 0);
            end else if (beat >= nb) begin
                checkOutput("done after last beat", done, 1);
            end else begin
                checkOutput("req_ready busy", req_ready, 0);
                checkOutput("mem_req", mem_req, 1);
                if (beat < nWb) begin
                    expAddr = vicBase + 32'(4 * beat);
                    checkOutput("wb mem_we", mem_we, 1);
                    checkOutput("wb mem_addr", mem_addr, expAddr);
                    checkOutput("wb vic_idx", vic_idx, beat);
                    checkOutput("wb mem_wdata", mem_wdata, 32'hBEEF_0000 | 32'(beat));
                    checkOutput("fill_we in wb", fill_we, 0);
                end else begin
                    f = beat - nWb;
                    i = (firstIdx(v.addr) + f) % 16;
                    expAddr = lineBase + 32'(4 * i);
                    checkOutput("fill mem_we", mem_we, 0);
                    checkOutput("fill mem_addr", mem_addr, expAddr);
                    checkOutput("fill_we", fill_we, mem_ack);
                    if (mem_ack) begin
                        checkOutput("fill_idx", fill_idx, i);
                        checkOutput("fill_data", fill_data, expAddr ^ 32'hC0DE_0000);
                    end
                end
                if (fill_we) fills++;
            end
            @(posedge clk);
            if (doneCyc < 0) begin
                if (mem_ack && beat < nb) begin
                    beat++;
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end
        end
        checkOutput("done cycle", doneCyc, v.expDone);
        checkOutput("fill_we pulses", fills, 16);
        @(negedge clk);
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("done one-shot", done, 0);
        checkOutput("req_ready after done", req_ready, 1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1234, 1'b0, 32'h0000_0000, 1, 0, 17};
        vecs[1] = '{32'h0000_2040, 1'b1, 32'h0000_A000, 1, 0, 33};
        vecs[2] = '{32'h0000_1234, 1'b0, 32'h0000_0000, 3, 0, 49};
        vecs[3] = '{32'h0000_2040, 1'b1, 32'h0000_A03F, 2, 5, 65};
        vecs[4] = '{32'h0000_3FFC, 1'b0, 32'h0000_0000, 1, 0, 17};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_dirty = 1'b0;
        req_victim_addr = '0; mem_ack = 1'b0;
        #1;
        checkOutput("reset req_ready", req_ready, 1);
        checkOutput("reset mem_req", mem_req, 0);
        checkOutput("reset mem_we", mem_we, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        checkOutput("reset mem_wdata", mem_wdata, 0);
        checkOutput("reset fill_we", fill_we, 0);
        checkOutput("reset fill_idx", fill_idx, 0);
        checkOutput("reset fill_data", fill_data, 0);
        checkOutput("reset vic_idx", vic_idx, 0);
        checkOutput("reset done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            $display("[TB] vector %0d addr %h dirty %0d period %0d", k,
                     vecs[k].addr, vecs[k].dirty, vecs[k].period);
            applyStimulus(vecs[k]);
        end

        // Reset during fill beat 5 must abort at once with no done pulse.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_1234; req_dirty = 1'b0; mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("mem_req before reset", mem_req, 1);
        checkOutput("fill_idx beat 5", fill_idx, (firstIdx(32'h0000_1234) + 5) % 16);
        rst = 1'b1;
        #1;
        checkOutput("mem_req async drop", mem_req, 0);
        checkOutput("fill_we async drop", fill_we, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("no done in reset", done, 0);
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        checkOutput("req_ready after reset", req_ready, 1);
        applyStimulus(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
